// File: rtl/blink_multi.sv
// blink_multi: multi-channel LED blink controller.
// One shared down-counting timebase feeds NUM_CH channels. Each channel is
// off, solid, free-running blink, or a counted burst with busy/done handshake.
// Optional build macro: BLINK_STAGGER_EN. When it is defined, odd-index
// channels show the inverted blink phase in modes 10 and 11. Burst timing and
// done behaviour are the same either way.
module blink_multi #(
   parameter int NUM_CH        = 4,
   parameter int PERIOD_CYCLES = 100_000_000,
   parameter int ON_CYCLES     = 50_000_000,
   parameter int CNT_W         = 27,
   parameter int BURST_W       = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic [2*NUM_CH-1:0]   mode,
   input  logic [BURST_W-1:0]    burst_len,
   input  logic [NUM_CH-1:0]     start,
   output logic [NUM_CH-1:0]     led,
   output logic [NUM_CH-1:0]     busy,
   output logic [NUM_CH-1:0]     done
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERIOD_CYCLES - 1);
   // The lit phase occupies the top ON_CYCLES counts of each period.
   // When ON_CYCLES equals PERIOD_CYCLES the threshold is 0, so the LED is always lit.
   localparam logic [CNT_W-1:0] ON_TH   = CNT_W'(PERIOD_CYCLES - ON_CYCLES);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RUN} burst_st_t;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             phase_on, wrap;

   // Next value of the shared timebase: count down, reload at 0, freeze when disabled.
   always_comb begin
      cnt_d = cnt_q;
      if (en) cnt_d = (cnt_q == '0) ? CNT_MAX : cnt_q - CNT_W'(1);
   end

   // Register the timebase.
   always_ff @(posedge clk) begin
      if (!reset) cnt_q <= CNT_MAX;
      else        cnt_q <= cnt_d;
   end

   assign phase_on = (cnt_q >= ON_TH);
   assign wrap     = en && (cnt_q == '0);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
`ifdef BLINK_STAGGER_EN
      localparam bit INV = (i % 2) == 1;
`else
      localparam bit INV = 1'b0;
`endif
      logic [1:0]         ch_mode;
      logic               ph, is_burst, last_wrap;
      burst_st_t          state_q, state_d;
      logic [BURST_W-1:0] rem_q, rem_d;
      logic               led_q, led_d, busy_q, busy_d, done_q, done_d;

      assign ch_mode   = mode[2*i +: 2];
      assign ph        = phase_on ^ INV;
      assign is_burst  = (ch_mode == 2'b11);
      // Final wrap of a burst. The LED is blanked on this edge so that
      // inverted channels do not leak an extra lit cycle.
      assign last_wrap = wrap && (rem_q == BURST_W'(1));

      // Burst FSM next state plus the LED/busy/done outputs it registers.
      always_comb begin
         state_d = state_q;
         rem_d   = rem_q;
         done_d  = 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (en && start[i] && is_burst) begin
                  if (burst_len == '0) done_d = 1'b1;
                  else begin
                     rem_d   = burst_len;
                     state_d = ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (!is_burst)  state_d = ST_IDLE;
               else if (wrap)  state_d = ST_RUN;
            end
            ST_RUN: begin
               if (!is_burst) state_d = ST_IDLE;
               else if (wrap) begin
                  if (last_wrap) begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end else begin
                     rem_d = rem_q - BURST_W'(1);
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
         busy_d = (state_d != ST_IDLE);
         case (ch_mode)
            2'b00:   led_d = 1'b0;
            2'b01:   led_d = 1'b1;
            2'b10:   led_d = ph;
            default: led_d = (state_q == ST_RUN) && !last_wrap && ph;
         endcase
      end

      // Per-channel state and output registers.
      always_ff @(posedge clk) begin
         if (!reset) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
         end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
         end
      end

      assign led[i]  = led_q;
      assign busy[i] = busy_q;
      assign done[i] = done_q;
   end

endmodule

// File: tb/tb_blink_multi.sv
// Directed bench for blink_multi with PERIOD=10, ON=4, four channels.
module tb_blink_multi;
   localparam int NUM_CH = 4, PERIOD = 10, ON = 4, CNT_W = 4, BURST_W = 4;
`ifdef BLINK_STAGGER_EN
   localparam bit STAG = 1'b1;
`else
   localparam bit STAG = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                reset = 1'b0;
   logic                en = 1'b1;
   logic [2*NUM_CH-1:0] mode = '0;
   logic [BURST_W-1:0]  burst_len = '0;
   logic [NUM_CH-1:0]   start = '0;
   logic [NUM_CH-1:0]   led, busy, done;

   int vectors = 0;
   int miscompares = 0;
   int k = 0;

   blink_multi #(.NUM_CH(NUM_CH), .PERIOD_CYCLES(PERIOD), .ON_CYCLES(ON),
                 .CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .burst_len(burst_len),
      .start(start), .led(led), .busy(busy), .done(done));

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      k++;
   endtask

   // Apply reset for two edges with the given inputs set up, then release it.
   // The next edge is k=1.
   task automatic do_reset(input logic [2*NUM_CH-1:0] m);
      reset = 1'b0;
      en = 1'b1;
      start = '0;
      mode = m;
      step();
      step();
      reset = 1'b1;
      k = 0;
   endtask

   function automatic logic [3:0] blink_pat(input bit lit);
      if (STAG) return lit ? 4'h5 : 4'hA;
      return lit ? 4'hF : 4'h0;
   endfunction

   task automatic test_reset();
      reset = 1'b0;
      mode = 8'hFF;
      start = 4'hF;
      burst_len = 4'd2;
      step();
      step();
      vectors++;
      if ({led, busy, done} !== 12'h000) begin
         miscompares++;
         $display("FAIL reset_outputs: led/busy/done=%h expected 000", {led, busy, done});
      end
      start = '0;
   endtask

   task automatic test_blink();
      do_reset(8'hAA);
      for (int i = 1; i <= 11; i++) begin
         step();
         vectors++;
         if (led !== blink_pat((k % 10) >= 1 && (k % 10) <= 4)) begin
            miscompares++;
            $display("FAIL blink k=%0d: led=%h expected %h", k, led,
                     blink_pat((k % 10) >= 1 && (k % 10) <= 4));
         end
      end
   endtask

   task automatic test_mode_change();
      do_reset(8'hAA);
      for (int i = 1; i <= 7; i++) step();
      mode[1:0] = 2'b01;
      for (int i = 8; i <= 12; i++) begin
         step();
         vectors++;
         if (led[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL solid k=%0d: led0=%b expected 1", k, led[0]);
         end
      end
      mode[1:0] = 2'b00;
      step();
      vectors++;
      if (led[0] !== 1'b0) begin
         miscompares++;
         $display("FAIL off k=%0d: led0=%b expected 0", k, led[0]);
      end
   endtask

   // Burst of 3 on ch1. A second start with a different length mid-burst must be ignored.
   task automatic test_burst();
      logic [2:0] exp;
      logic       lit;
      do_reset(8'b00_00_11_00);
      burst_len = 4'd3;
      for (int i = 1; i <= 45; i++) begin
         step();
         if (STAG) lit = (k >= 11 && k <= 39) && ((k % 10) >= 5 || (k % 10) == 0);
         else      lit = (k >= 11 && k <= 39) && ((k % 10) >= 1 && (k % 10) <= 4);
         exp = {lit, (k >= 3 && k <= 39), (k == 40)};
         vectors++;
         if ({led[1], busy[1], done[1]} !== exp || {led[3:2], led[0]} !== 3'b000) begin
            miscompares++;
            $display("FAIL burst k=%0d: led/busy/done=%b%b%b led=%h expected %b",
                     k, led[1], busy[1], done[1], led, exp);
         end
         start[1] = (k == 2) || (k == 20);
         if (k == 20) burst_len = 4'd1;
      end
   endtask

   task automatic test_burst_zero();
      do_reset(8'b00_11_00_10);
      burst_len = 4'd0;
      for (int i = 1; i <= 8; i++) begin
         step();
         vectors++;
         if (done[2] !== (k == 3) || busy[2] !== 1'b0 || led[2] !== 1'b0 ||
             busy[0] !== 1'b0 || done[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL burst_zero k=%0d: done=%b busy=%b led=%b expected done2=%b",
                     k, done, busy, led, (k == 3));
         end
         start = (k == 2) ? 4'b0101 : 4'b0000;
      end
   endtask

   task automatic test_freeze();
      int  ticks = 0;
      logic [3:0] exp;
      do_reset(8'hAA);
      for (int i = 1; i <= 20; i++) begin
         exp = blink_pat((ticks % 10) < 4);
         if (en) ticks++;
         step();
         vectors++;
         if (led !== exp) begin
            miscompares++;
            $display("FAIL freeze k=%0d: led=%h expected %h", k, led, exp);
         end
         if (k == 2) en = 1'b0;
         if (k == 9) en = 1'b1;
      end
      // Hand-derived landmarks: the first lit phase lasts through k=11, the next begins at k=18.
      vectors++;
      if (led !== blink_pat(1'b1)) begin
         miscompares++;
         $display("FAIL freeze_period k=%0d: led=%h expected %h", k, led, blink_pat(1'b1));
      end
   endtask

   task automatic test_abort();
      do_reset(8'b00_00_11_00);
      burst_len = 4'd3;
      for (int i = 1; i <= 30; i++) begin
         step();
         if (k >= 13) begin
            vectors++;
            if (busy[1] !== 1'b0 || done[1] !== 1'b0 || led[1] !== 1'b0) begin
               miscompares++;
               $display("FAIL abort k=%0d: busy=%b done=%b led=%b expected 000",
                        k, busy[1], done[1], led[1]);
            end
         end
         start[1] = (k == 2);
         if (k == 12) mode[3:2] = 2'b00;
      end
   endtask

   task automatic test_reset_mid_burst();
      do_reset(8'b00_00_11_00);
      burst_len = 4'd3;
      for (int i = 1; i <= 15; i++) begin
         step();
         start[1] = (k == 2);
      end
      reset = 1'b0;
      step();
      vectors++;
      if ({led, busy, done} !== 12'h000) begin
         miscompares++;
         $display("FAIL reset_mid: led/busy/done=%h expected 000", {led, busy, done});
      end
      reset = 1'b1;
      for (int i = 0; i < 45; i++) begin
         step();
         vectors++;
         if (busy[1] !== 1'b0 || done[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL after_reset k=%0d: busy=%b done=%b expected 0 0", k, busy[1], done[1]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_blink();
      test_mode_change();
      test_burst();
      test_burst_zero();
      test_freeze();
      test_abort();
      test_reset_mid_burst();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
